// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM encoding, frame constants and time conversion.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_BITS,
    ST_WAIT_IDLE,
    ST_FAIL
  } ps2_state_e;

  localparam int unsigned PS2_FRAME_FALLS = 11;
  localparam logic        PS2_ACK         = 1'b0;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
    logic [63:0] prod;
    prod = (64'(clk_hz) * 64'(us)) / 64'd1_000_000;
    return 32'(prod);
  endfunction

  // Bits shifted out on falls 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioner: 2-FF synchroniser, FILTER_LEN-sample glitch filter, one-cycle fall strobe.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    fall_d = level_q & ~level_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      meta_q  <= line_in;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, 10 bits on device falls, ACK check).
// Define PS2_TX_RETRY_EN to resend the latched byte up to MAX_RETRY times before reporting tx_error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned START_US   = 15000,
  parameter int unsigned FRAME_US   = 2000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int unsigned START_CYC   = us_to_cycles(CLK_HZ, START_US);
  localparam int unsigned FRAME_CYC   = us_to_cycles(CLK_HZ, FRAME_US);
  localparam int unsigned MAX_AB      = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
  localparam int unsigned MAX_CYC     = (MAX_AB > FRAME_CYC) ? MAX_AB : FRAME_CYC;
  localparam int unsigned TW          = $clog2(MAX_CYC);

  ps2_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    shift_q, shift_d;
  logic          ok_q, ok_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  logic [7:0]    data_q, data_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
`else
  localparam int unsigned max_retry_unused = MAX_RETRY;
`endif

  logic clk_level, clk_fall, data_level, data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .line_in (ps2_clk_in),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .line_in (ps2_data_in),
    .level   (data_level),
    .fall    (data_fall_unused)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    ok_d      = ok_q;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    done_d    = 1'b0;
    error_d   = 1'b0;
`ifdef PS2_TX_RETRY_EN
    data_d      = data_q;
    retry_cnt_d = retry_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        timer_d  = '0;
        bitcnt_d = '0;
        ok_d     = 1'b0;
        if (tx_valid) begin
          shift_d  = ps2_frame(tx_data);
          state_d  = ST_INHIBIT;
          clk_oe_d = 1'b1;
`ifdef PS2_TX_RETRY_EN
          data_d      = tx_data;
          retry_cnt_d = '0;
`endif
        end
      end
      ST_INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = (timer_q >= TW'(INHIBIT_CYC - 2));
        if (timer_q == TW'(INHIBIT_CYC - 1)) begin
          state_d   = ST_REQ;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
        end
      end
      ST_REQ: begin
        data_oe_d = 1'b1;
        if (clk_fall) begin
          state_d   = ST_BITS;
          bitcnt_d  = 4'd1;
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b1, shift_q[9:1]};
        end else if (timer_q >= TW'(START_CYC - 1)) begin
          state_d   = ST_FAIL;
          data_oe_d = 1'b0;
        end
      end
      ST_BITS: begin
        data_oe_d = data_oe_q;
        if (clk_fall) begin
          if (bitcnt_q == 4'(PS2_FRAME_FALLS - 1)) begin
            data_oe_d = 1'b0;
            ok_d      = (data_level == PS2_ACK);
            state_d   = (data_level == PS2_ACK) ? ST_WAIT_IDLE : ST_FAIL;
          end else begin
            bitcnt_d  = bitcnt_q + 4'd1;
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b1, shift_q[9:1]};
          end
        end else if (timer_q >= TW'(FRAME_CYC - 1)) begin
          state_d   = ST_FAIL;
          data_oe_d = 1'b0;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_level && data_level) begin
          state_d = ST_IDLE;
          done_d  = ok_q;
          error_d = ~ok_q;
        end else if (timer_q >= TW'(FRAME_CYC - 1)) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      ST_FAIL: begin
        ok_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
        if (retry_cnt_q < RW'(MAX_RETRY)) begin
          retry_cnt_d = retry_cnt_q + RW'(1);
          state_d     = ST_INHIBIT;
          clk_oe_d    = 1'b1;
          shift_d     = ps2_frame(data_q);
        end else begin
          state_d = ST_WAIT_IDLE;
        end
`else
        state_d = ST_WAIT_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    // Every state times itself from entry.
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      ok_q      <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      data_q      <= '0;
      retry_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      ok_q      <= ok_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef PS2_TX_RETRY_EN
      data_q      <= data_d;
      retry_cnt_q <= retry_cnt_d;
`endif
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
